// File: rtl/jedro_1_data_ram_pkg.sv
// Shared constants and address helper for the jedro_1 data RAM responder.
package jedro_1_data_ram_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned BE_WIDTH_DEF   = DATA_WIDTH_DEF / 8;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Unsigned wrap makes addresses below base fail the same size compare.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [32:0] size);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] == 2'b00) && ({1'b0, offset} < size);
    endfunction

endpackage

// File: rtl/jedro_1_data_ram_ram_be.sv
// Single-port byte-enabled synchronous RAM with registered read data.
module jedro_1_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BW-1:0]         be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(BW); i++) begin
                    if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/jedro_1_data_ram.sv
// jedro_1 data-port responder: req/gnt with optional grant stall, 1-cycle rvalid response.
module jedro_1_data_ram
    import jedro_1_data_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned GNT_WAIT   = 0,
    localparam int unsigned BW        = DATA_WIDTH / 8,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic                  data_we_i,
    input  logic [BW-1:0]         data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o
);

    localparam logic [32:0] WIN_SIZE = 33'(4 * MEM_WORDS);

    logic [3:0]            stall_cnt_q, stall_cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  rd_q, rd_d;
    logic                  accept;
    logic                  addr_ok;
    logic [31:0]           offset;
    logic [AW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        data_gnt_o  = data_req_i && (stall_cnt_q == 4'(GNT_WAIT));
        accept      = data_req_i && data_gnt_o;
        addr_ok     = addr_in_window(data_addr_i, BASE_ADDR, WIN_SIZE);
        offset      = data_addr_i - BASE_ADDR;
        word_idx    = offset[AW+1:2];
        stall_cnt_d = (data_req_i && !data_gnt_o) ? stall_cnt_q + 4'd1 : 4'd0;
        rvalid_d    = accept;
        err_d       = accept && (addr_ok ? RESP_OK : RESP_ERR);
        rd_d        = accept && !data_we_i && addr_ok;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= 4'd0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
        end
    end

    // Invalid accesses still strobe the RAM for timing symmetry but never write.
    jedro_1_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_WORDS)
    ) u_ram (
        .clk   (clk_i),
        .en    (accept),
        .we    (data_we_i && addr_ok),
        .be    (data_be_i),
        .addr  (word_idx),
        .wdata (data_wdata_i),
        .rdata (ram_rdata)
    );

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = rvalid_q && err_q;
    assign data_rdata_o  = (rvalid_q && rd_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Directed bench for jedro_1_data_ram: one instance without grant stall, one with GNT_WAIT=3.
module tb_jedro_1_data_ram;

    logic        clk;
    logic        rstn;
    int          n_checks;
    int          n_fail;

    logic        a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;

    jedro_1_data_ram #(.DATA_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .data_req_i(a_req), .data_gnt_o(a_gnt), .data_we_i(a_we),
        .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
        .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata), .data_err_o(a_err));

    jedro_1_data_ram #(.DATA_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_WAIT(3)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .data_req_i(b_req), .data_gnt_o(b_gnt), .data_we_i(b_we),
        .data_be_i(b_be), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
        .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata), .data_err_o(b_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
    task automatic drive_a(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 1; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);
        n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", a_rvalid); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", a_err); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        n_checks++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_idle: got %b expected 0", a_gnt); end
        n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_stall: got %b expected 0", b_gnt); end
        @(posedge clk); #1;
        b_req = 0;
        rstn = 1'b1;
    endtask

    task automatic test_write_read();
        drive_a(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        n_checks++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", a_gnt); end
        n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", a_rvalid); end
        drive_a(1, 0, 4'hF, 32'h10, 32'h0);
        n_checks++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b expected 1", a_gnt); end
        n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_resp_rvalid: got %b expected 1", a_rvalid); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_resp_rdata: got %h expected 0", a_rdata); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL wr_resp_err: got %b expected 0", a_err); end
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_gnt: got %b expected 0", a_gnt); end
        n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_resp_rvalid: got %b expected 1", a_rvalid); end
        n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_resp_rdata: got %h expected deadbeef", a_rdata); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rd_resp_err: got %b expected 0", a_err); end
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 0", a_rvalid); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got %h expected 0", a_rdata); end
    endtask

    task automatic test_byte_enable();
        drive_a(1, 1, 4'b0101, 32'h10, 32'h11223344);
        drive_a(1, 0, 4'b0000, 32'h10, 32'h0);
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_enable_rdata: got %h expected de22be44", a_rdata); end
        drive_a(1, 1, 4'b0000, 32'h10, 32'hFFFFFFFF);
        drive_a(1, 0, 4'hF, 32'h10, 32'h0);
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_zero_noop: got %h expected de22be44", a_rdata); end
    endtask

    task automatic test_errors();
        drive_a(1, 1, 4'hF, 32'h0, 32'hCAFEF00D);
        drive_a(1, 0, 4'hF, 32'h12, 32'h0);
        n_checks++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL misalign_gnt: got %b expected 1", a_gnt); end
        drive_a(1, 0, 4'hF, 32'h1000, 32'h0);
        n_checks++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_gnt: got %b expected 1", a_gnt); end
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b expected 1", a_err); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %h expected 0", a_rdata); end
        drive_a(1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
        n_checks++; if (a_rvalid !== 1'b1 || a_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got rvalid %b err %b expected 1 1", a_rvalid, a_err); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rd_rdata: got %h expected 0", a_rdata); end
        drive_a(1, 0, 4'hF, 32'h0, 32'h0);
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", a_err); end
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL alias_err: got %b expected 0", a_err); end
        n_checks++; if (a_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_unchanged: got %h expected cafef00d", a_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word;
        for (int k = 0; k <= 16; k++) begin
            if (k < 8)       drive_a(1, 1, 4'hF, 32'(4 * k), 32'h11111111 * 32'(k + 1));
            else if (k < 16) drive_a(1, 0, 4'hF, 32'(4 * (k - 8)), 32'h0);
            else             drive_a(0, 0, 4'h0, 32'h0, 32'h0);
            if (k < 16) begin
                n_checks++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL stream_gnt[%0d]: got %b expected 1", k, a_gnt); end
            end
            if (k >= 1) begin
                n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL stream_rvalid[%0d]: got %b expected 1", k, a_rvalid); end
                exp_word = (k >= 9) ? 32'h11111111 * 32'(k - 8) : 32'h0;
                n_checks++; if (a_rdata !== exp_word) begin n_fail++; $display("FAIL stream_rdata[%0d]: got %h expected %h", k, a_rdata, exp_word); end
            end
        end
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL stream_end_rvalid: got %b expected 0", a_rvalid); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            drive_b(1, 1, 4'hF, 32'h8, 32'h0BADF00D);
            n_checks++; if (b_gnt !== (c == 3)) begin n_fail++; $display("FAIL stall_wr_gnt[%0d]: got %b expected %b", c, b_gnt, (c == 3)); end
            n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_wr_rvalid[%0d]: got %b expected 0", c, b_rvalid); end
        end
        drive_b(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (b_rvalid !== 1'b1 || b_err !== 1'b0) begin n_fail++; $display("FAIL stall_wr_resp: got rvalid %b err %b expected 1 0", b_rvalid, b_err); end
        for (int c = 0; c < 4; c++) begin
            drive_b(1, 0, 4'hF, 32'h8, 32'h0);
            n_checks++; if (b_gnt !== (c == 3)) begin n_fail++; $display("FAIL stall_rd_gnt[%0d]: got %b expected %b", c, b_gnt, (c == 3)); end
        end
        drive_b(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL stall_rd_rvalid: got %b expected 1", b_rvalid); end
        n_checks++; if (b_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL stall_rd_rdata: got %h expected 0badf00d", b_rdata); end
        for (int c = 0; c < 2; c++) begin
            drive_b(1, 0, 4'hF, 32'h8, 32'h0);
            n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL withdraw_gnt[%0d]: got %b expected 0", c, b_gnt); end
        end
        drive_b(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL withdraw_rvalid: got %b expected 0", b_rvalid); end
        for (int c = 0; c < 4; c++) begin
            drive_b(1, 0, 4'hF, 32'h8, 32'h0);
            n_checks++; if (b_gnt !== (c == 3)) begin n_fail++; $display("FAIL cnt_cleared_gnt[%0d]: got %b expected %b", c, b_gnt, (c == 3)); end
        end
        drive_b(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (b_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL cnt_cleared_rdata: got %h expected 0badf00d", b_rdata); end
    endtask

    task automatic test_reset_mid();
        drive_a(1, 1, 4'hF, 32'h14, 32'h55AA55AA);
        drive_a(1, 0, 4'hF, 32'h14, 32'h0);
        @(posedge clk); #1;
        a_req = 0;
        rstn  = 1'b0;
        #1;
        n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 0", a_rvalid); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", a_err); end
        n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", a_rdata); end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_a(0, 0, 4'h0, 32'h0, 32'h0);
            n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL postrst_rvalid[%0d]: got %b expected 0", c, a_rvalid); end
        end
        drive_a(1, 0, 4'hF, 32'h14, 32'h0);
        drive_a(0, 0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (a_rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL postrst_rdata: got %h expected 55aa55aa", a_rdata); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
